// File: rtl/corr_pkg.sv
// Shared state type and pair-count sizing helpers for the correlator sequencer.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } corr_state_t;

  // Number of unordered antenna pairs including autocorrelations (a<=b).
  function automatic int npairs(input int antennas);
    return antennas * (antennas + 1) / 2;
  endfunction

  function automatic int pair_bits(input int antennas);
    return (npairs(antennas) > 1) ? $clog2(npairs(antennas)) : 1;
  endfunction

endpackage

// File: rtl/pair_counter.sv
// Triangular (a,b) antenna-pair walker with a linear pair index.
// Order is (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1); advancing past the last pair wraps to (0,0).
module pair_counter
  import corr_pkg::*;
#(
  parameter int ANTENNAS = 4,
  parameter int ABITS    = 2,
  parameter int PBITS    = pair_bits(ANTENNAS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [ABITS-1:0] a_o,
  output logic [ABITS-1:0] b_o,
  output logic [PBITS-1:0] pair_o,
  output logic             auto_o,
  output logic             last_pair_o
);

  localparam logic [ABITS-1:0] A_MAX = ABITS'(ANTENNAS - 1);
  localparam logic [PBITS-1:0] P_MAX = PBITS'(npairs(ANTENNAS) - 1);

  logic [ABITS-1:0] r_a;
  logic [ABITS-1:0] r_b;
  logic [PBITS-1:0] r_pair;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pair <= '0;
    end else if (advance_i) begin
      if (r_pair == P_MAX) begin
        r_a    <= '0;
        r_b    <= '0;
        r_pair <= '0;
      end else if (r_b == A_MAX) begin
        // Row finished: next row starts on its own autocorrelation.
        r_a    <= r_a + 1'b1;
        r_b    <= r_a + 1'b1;
        r_pair <= r_pair + 1'b1;
      end else begin
        r_b    <= r_b + 1'b1;
        r_pair <= r_pair + 1'b1;
      end
    end
  end

  assign a_o         = r_a;
  assign b_o         = r_b;
  assign pair_o      = r_pair;
  assign auto_o      = (r_a == r_b);
  assign last_pair_o = (r_pair == P_MAX);

endmodule

// File: rtl/correlator_sequencer.sv
// Walks one correlate unit over every antenna pair: issues sample-buffer reads, then
// the valid/first/last/auto strobes and selects one clock later, aligned to read data.
module correlator_sequencer
  import corr_pkg::*;
#(
  parameter int ANTENNAS = 4,
  parameter int SAMPLES  = 16,
  parameter int SBITS    = 4,
  parameter int ABITS    = 2,
  parameter int PBITS    = pair_bits(ANTENNAS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_o,
  output logic [SBITS-1:0] raddr_o,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             auto_o,
  output logic [ABITS-1:0] asel_o,
  output logic [ABITS-1:0] bsel_o,
  output logic [PBITS-1:0] pair_o
);

  // Compare against SAMPLES-1 rather than the counter's full range.
  localparam logic [SBITS-1:0] T_MAX = SBITS'(SAMPLES - 1);

  corr_state_t      r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_end;
  logic [SBITS-1:0] r_t;

  logic             r_rd;
  logic [SBITS-1:0] r_raddr;
  logic             r_first_iss;
  logic             r_last_iss;
  logic             r_auto_iss;
  logic [ABITS-1:0] r_asel_iss;
  logic [ABITS-1:0] r_bsel_iss;
  logic [PBITS-1:0] r_pair_iss;

  logic             r_valid;
  logic             r_first;
  logic             r_last;
  logic             r_auto;
  logic [ABITS-1:0] r_asel;
  logic [ABITS-1:0] r_bsel;
  logic [PBITS-1:0] r_pair;

  logic             w_start;
  logic             w_issue;
  logic             w_t_last;
  logic             w_advance;
  logic [ABITS-1:0] w_a;
  logic [ABITS-1:0] w_b;
  logic [PBITS-1:0] w_pair;
  logic             w_auto;
  logic             w_last_pair;

  assign w_start   = (r_state == IDLE) && start_i;
  assign w_issue   = (r_state == RUN) && !r_end && !stall_i;
  assign w_t_last  = (r_t == T_MAX);
  assign w_advance = w_issue && w_t_last;

  pair_counter #(
    .ANTENNAS (ANTENNAS),
    .ABITS    (ABITS),
    .PBITS    (PBITS)
  ) u_pair_counter (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (w_start),
    .advance_i   (w_advance),
    .a_o         (w_a),
    .b_o         (w_b),
    .pair_o      (w_pair),
    .auto_o      (w_auto),
    .last_pair_o (w_last_pair)
  );

  // FSM plus issue stage; r_end marks that every read of the pass has gone out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_end       <= 1'b0;
      r_t         <= '0;
      r_rd        <= 1'b0;
      r_raddr     <= '0;
      r_first_iss <= 1'b0;
      r_last_iss  <= 1'b0;
      r_auto_iss  <= 1'b0;
      r_asel_iss  <= '0;
      r_bsel_iss  <= '0;
      r_pair_iss  <= '0;
    end else begin
      r_rd        <= 1'b0;
      r_raddr     <= '0;
      r_first_iss <= 1'b0;
      r_last_iss  <= 1'b0;
      r_auto_iss  <= 1'b0;
      r_asel_iss  <= '0;
      r_bsel_iss  <= '0;
      r_pair_iss  <= '0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_end   <= 1'b0;
            r_t     <= '0;
          end
        end
        RUN: begin
          if (r_end) begin
            r_state <= DRAIN;
            r_end   <= 1'b0;
          end else if (!stall_i) begin
            r_rd        <= 1'b1;
            r_raddr     <= r_t;
            r_first_iss <= (r_t == '0);
            r_last_iss  <= w_t_last;
            r_auto_iss  <= w_auto;
            r_asel_iss  <= w_a;
            r_bsel_iss  <= w_b;
            r_pair_iss  <= w_pair;
            if (w_t_last) begin
              r_t <= '0;
              if (w_last_pair) begin
                r_end <= 1'b1;
              end
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Strobe stage: one clock behind the read so strobes line up with buffer data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_auto  <= 1'b0;
      r_asel  <= '0;
      r_bsel  <= '0;
      r_pair  <= '0;
    end else begin
      r_valid <= r_rd;
      r_first <= r_first_iss;
      r_last  <= r_last_iss;
      r_auto  <= r_auto_iss;
      r_asel  <= r_asel_iss;
      r_bsel  <= r_bsel_iss;
      r_pair  <= r_pair_iss;
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign rd_o    = r_rd;
  assign raddr_o = r_raddr;
  assign valid_o = r_valid;
  assign first_o = r_first;
  assign last_o  = r_last;
  assign auto_o  = r_auto;
  assign asel_o  = r_asel;
  assign bsel_o  = r_bsel;
  assign pair_o  = r_pair;

endmodule

// File: tb/tb_correlator_sequencer.sv
// Self-checking bench: randomized stall/start stimulus against a pair-order reference model.
module tb_correlator_sequencer;

  localparam int ANT = 4;
  localparam int SMP = 16;
  localparam int SB  = 4;
  localparam int AB  = 2;
  localparam int PB  = 4;
  localparam int NP  = ANT * (ANT + 1) / 2;
  localparam int NV  = NP * SMP;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          rd_o;
  logic [SB-1:0] raddr_o;
  logic          valid_o;
  logic          first_o;
  logic          last_o;
  logic          auto_o;
  logic [AB-1:0] asel_o;
  logic [AB-1:0] bsel_o;
  logic [PB-1:0] pair_o;

  int checks = 0;
  int errors = 0;

  // Reference sequence: one entry per expected strobe, in pass order.
  int exp_t [NV];
  int exp_a [NV];
  int exp_b [NV];
  int exp_p [NV];

  always #5 clock = ~clock;

  correlator_sequencer #(
    .ANTENNAS (ANT),
    .SAMPLES  (SMP),
    .SBITS    (SB),
    .ABITS    (AB),
    .PBITS    (PB)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start_i (start_i),
    .stall_i (stall_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .rd_o    (rd_o),
    .raddr_o (raddr_o),
    .valid_o (valid_o),
    .first_o (first_o),
    .last_o  (last_o),
    .auto_o  (auto_o),
    .asel_o  (asel_o),
    .bsel_o  (bsel_o),
    .pair_o  (pair_o)
  );

  function automatic void build_model();
    int k;
    int p;
    k = 0;
    p = 0;
    for (int a = 0; a < ANT; a++) begin
      for (int b = a; b < ANT; b++) begin
        for (int t = 0; t < SMP; t++) begin
          exp_t[k] = t;
          exp_a[k] = a;
          exp_b[k] = b;
          exp_p[k] = p;
          k++;
        end
        p++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one pass and checks every cycle; abort_at>0 returns after that many strobes.
  task automatic run_pass(input string tag, input int stall_pct, input bit poke_run,
                          input bit poke_done, input int abort_at, output int done_cycle);
    int        rd_idx;
    int        v_idx;
    int        n_first;
    int        n_last;
    int        k;
    int        last_valid_k;
    bit        seen_done;
    bit        st;
    logic      prev_rd;
    logic [15:0] auto_mask;
    rd_idx = 0; v_idx = 0; n_first = 0; n_last = 0; k = 0; last_valid_k = -10;
    seen_done = 1'b0; auto_mask = '0; done_cycle = -1;

    start_i = 1'b1;
    stall_i = 1'b0;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", tag, busy_o);
    end

    while (!seen_done && k < 3000) begin
      st      = ($urandom_range(0, 99) < stall_pct);
      stall_i = st;
      start_i = poke_run && ($urandom_range(0, 9) == 0);
      prev_rd = rd_o;
      tick();
      k++;

      checks++;
      if (valid_o !== prev_rd) begin
        errors++;
        $display("FAIL %s valid_latency cyc %0d got %b want %b", tag, k, valid_o, prev_rd);
      end
      if (st) begin
        checks++;
        if (rd_o !== 1'b0) begin
          errors++;
          $display("FAIL %s rd_during_stall cyc %0d got %b want 0", tag, k, rd_o);
        end
      end
      if (rd_o === 1'b1) begin
        checks++;
        if (rd_idx >= NV) begin
          errors++;
          $display("FAIL %s extra_read cyc %0d got read %0d want at most %0d", tag, k, rd_idx + 1, NV);
        end else if (raddr_o !== SB'(exp_t[rd_idx])) begin
          errors++;
          $display("FAIL %s raddr idx %0d got %0d want %0d", tag, rd_idx, raddr_o, exp_t[rd_idx]);
        end
        rd_idx++;
      end
      if (valid_o === 1'b1) begin
        checks++;
        if (v_idx >= NV) begin
          errors++;
          $display("FAIL %s extra_valid cyc %0d got strobe %0d want at most %0d", tag, k, v_idx + 1, NV);
        end else if (first_o !== (exp_t[v_idx] == 0) || last_o !== (exp_t[v_idx] == SMP - 1) ||
                     auto_o !== (exp_a[v_idx] == exp_b[v_idx]) || asel_o !== AB'(exp_a[v_idx]) ||
                     bsel_o !== AB'(exp_b[v_idx]) || pair_o !== PB'(exp_p[v_idx])) begin
          errors++;
          $display("FAIL %s strobe idx %0d got f%b l%b au%b a%0d b%0d p%0d want f%b l%b au%b a%0d b%0d p%0d",
                   tag, v_idx, first_o, last_o, auto_o, asel_o, bsel_o, pair_o,
                   exp_t[v_idx] == 0, exp_t[v_idx] == SMP - 1, exp_a[v_idx] == exp_b[v_idx],
                   exp_a[v_idx], exp_b[v_idx], exp_p[v_idx]);
        end
        if (first_o === 1'b1) n_first++;
        if (last_o === 1'b1) n_last++;
        if (auto_o === 1'b1) auto_mask[pair_o] = 1'b1;
        v_idx++;
        last_valid_k = k;
        if (abort_at > 0 && v_idx == abort_at) break;
      end else begin
        checks++;
        if ({first_o, last_o, auto_o, asel_o, bsel_o, pair_o} !== '0) begin
          errors++;
          $display("FAIL %s strobes_without_valid cyc %0d got f%b l%b au%b a%0d b%0d p%0d want all 0",
                   tag, k, first_o, last_o, auto_o, asel_o, bsel_o, pair_o);
        end
      end
      if (done_o === 1'b1) begin
        seen_done  = 1'b1;
        done_cycle = k;
        checks++;
        if (k != last_valid_k + 1 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done_timing cyc %0d busy %b got last strobe at %0d want done one cycle after it, busy 0",
                   tag, k, busy_o, last_valid_k);
        end
      end else begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_in_pass cyc %0d got %b want 1", tag, k, busy_o);
        end
      end
    end
    stall_i = 1'b0;
    start_i = 1'b0;

    if (abort_at > 0) begin
      checks++;
      if (v_idx != abort_at) begin
        errors++;
        $display("FAIL %s abort_point got %0d strobes want %0d", tag, v_idx, abort_at);
      end
    end else if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no done_o after %0d cycles want done", tag, k);
    end else begin
      checks++;
      if (rd_idx != NV || v_idx != NV || n_first != NP || n_last != NP) begin
        errors++;
        $display("FAIL %s counts got rd %0d valid %0d first %0d last %0d want %0d %0d %0d %0d",
                 tag, rd_idx, v_idx, n_first, n_last, NV, NV, NP, NP);
      end
      checks++;
      if (auto_mask !== 16'h0291) begin
        errors++;
        $display("FAIL %s auto_pairs got %h want 0291", tag, auto_mask);
      end
      // Cycle the DUT sits in DONE: optionally try to restart it there.
      start_i = poke_done;
      for (int i = 0; i < 8; i++) begin
        tick();
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || rd_o !== 1'b0 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done cyc %0d got done %b busy %b rd %b valid %b want all 0",
                   tag, i, done_o, busy_o, rd_o, valid_o);
        end
      end
    end
    $display("pass %s strobes %0d reads %0d done_cycle %0d", tag, v_idx, rd_idx, done_cycle);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_i = 1'b0;
    stall_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall_i = i[0];
      tick();
      checks++;
      if ({busy_o, done_o, rd_o, raddr_o, valid_o, first_o, last_o, auto_o, asel_o, bsel_o, pair_o} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got busy %b done %b rd %b raddr %0d valid %b pair %0d want all 0",
                 i, busy_o, done_o, rd_o, raddr_o, valid_o, pair_o);
      end
    end
    stall_i = 1'b0;
    $display("reset idle checked 10 cycles");
  endtask

  task automatic test_full_pass();
    int dc;
    run_pass("full", 0, 1'b0, 1'b0, 0, dc);
    // Counted from the cycle start_i is driven: 160 reads + drain + done.
    checks++;
    if (dc + 1 != NV + 3) begin
      errors++;
      $display("FAIL full_done_latency got %0d want %0d", dc + 1, NV + 3);
    end
  endtask

  task automatic test_stall();
    int dc;
    run_pass("stall30", 30, 1'b0, 1'b0, 0, dc);
    checks++;
    if (dc <= NV + 2) begin
      errors++;
      $display("FAIL stall_latency got %0d want more than %0d", dc, NV + 2);
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    run_pass("start_pokes", 20, 1'b1, 1'b1, 0, dc);
  endtask

  task automatic test_reset_mid_pass();
    int dc;
    run_pass("abort50", 0, 1'b0, 1'b0, 50, dc);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || rd_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got valid %b busy %b done %b rd %b want all 0", valid_o, busy_o, done_o, rd_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc %0d got done %b valid %b busy %b want 0", i, done_o, valid_o, busy_o);
      end
    end
    run_pass("after_abort", 0, 1'b0, 1'b0, 0, dc);
    checks++;
    if (dc + 1 != NV + 3) begin
      errors++;
      $display("FAIL after_abort_latency got %0d want %0d", dc + 1, NV + 3);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_full_pass();
    test_stall();
    test_start_ignored();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
